mem_access_unit: RTL and testbench

//  Sub-word load/store adapter between datapath (ALU result + rt value) and word-only data memory.

---
 rtl/mem_pkg.sv | 46 ++++
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/load_align.sv | 37 +++
 rtl/mem_access_unit.sv | 107 ++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the sub-word load/store adapter: op encodings, FSM states
// and op-class helpers used by the top, the load aligner and the interface.
package mem_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_byte(input mem_op_e op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic is_half(input mem_op_e op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    // Byte ops can start on any lane; halfwords need an even address, words a multiple of four.
    function automatic logic misaligned(input mem_op_e op, input logic [1:0] lo);
        if (is_byte(op)) begin
            return 1'b0;
        end
        if (is_half(op)) begin
            return lo[0];
        end
        return lo != 2'd0;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Datapath-side and data-memory-side signals of the load/store adapter.
interface mem_access_unit_if;
    import mem_pkg::*;

    logic            mem_req;
    mem_op_e         mem_op;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] dm_rdata;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic            dm_we;
    logic [XLEN-1:0] load_data;
    logic            stall;
    logic            fault;
    logic [XLEN-1:0] fault_addr;

    modport slave (
        input  mem_req, mem_op, addr, wdata, dm_rdata,
        output dm_addr, dm_wdata, dm_we, load_data, stall, fault, fault_addr
    );

    modport master (
        output mem_req, mem_op, addr, wdata, dm_rdata,
        input  dm_addr, dm_wdata, dm_we, load_data, stall, fault, fault_addr
    );

endinterface

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension of a memory word for loads.
module load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      lane,
    input  mem_op_e         op,
    output logic [XLEN-1:0] load_data_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (lane)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data_c = rdata;
        case (op)
            OP_LB:   load_data_c = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_data_c = {24'd0, byte_v};
            OP_LH:   load_data_c = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_data_c = {16'd0, half_v};
            default: load_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Sub-word load/store adapter in front of a word-only data memory: same-cycle
// loads, single-cycle SW, two-cycle read-modify-write for SB/SH, sticky fault capture.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DM_ADDR_W = 12
) (
    input  logic             clock,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    state_e          state;
    logic [XLEN-1:0] rmw_addr;
    logic [XLEN-1:0] rmw_word;
    logic            fault_q;
    logic [XLEN-1:0] fault_addr_q;

    logic [XLEN-1:0] aligned_c;
    logic [XLEN-1:0] merged_c;
    logic            out_of_range_c;
    logic            bad_c;
    logic            sub_store_c;
    logic            start_rmw_c;

    load_align u_load_align (
        .rdata       (bus.dm_rdata),
        .lane        (bus.addr[1:0]),
        .op          (bus.mem_op),
        .load_data_c (aligned_c)
    );

    // Any address bit above the decoded range means the access targets nothing.
    assign out_of_range_c = (bus.addr >> DM_ADDR_W) != '0;
    assign bad_c          = bus.mem_req && (misaligned(bus.mem_op, bus.addr[1:0]) || out_of_range_c);
    assign sub_store_c    = is_store(bus.mem_op) && (is_byte(bus.mem_op) || is_half(bus.mem_op));
    assign start_rmw_c    = (state == ST_IDLE) && bus.mem_req && !bad_c && sub_store_c;

    // Replace the addressed lane(s) of the current memory word with the store data.
    always_comb begin
        merged_c = bus.dm_rdata;
        if (is_byte(bus.mem_op)) begin
            case (bus.addr[1:0])
                2'd0: merged_c[7:0]   = bus.wdata[7:0];
                2'd1: merged_c[15:8]  = bus.wdata[7:0];
                2'd2: merged_c[23:16] = bus.wdata[7:0];
                2'd3: merged_c[31:24] = bus.wdata[7:0];
                default: merged_c = bus.dm_rdata;
            endcase
        end else if (bus.addr[1]) begin
            merged_c[31:16] = bus.wdata[15:0];
        end else begin
            merged_c[15:0] = bus.wdata[15:0];
        end
    end

    // Memory-side controls follow the instruction in the same cycle; reset blocks any write.
    always_comb begin
        bus.dm_addr  = bus.addr;
        bus.dm_wdata = bus.wdata;
        bus.dm_we    = 1'b0;
        bus.stall    = 1'b0;
        if (state == ST_WRITE) begin
            bus.dm_addr  = rmw_addr;
            bus.dm_wdata = rmw_word;
            bus.dm_we    = !reset;
        end else if (!reset && bus.mem_req && !bad_c) begin
            if (bus.mem_op == OP_SW) begin
                bus.dm_we = 1'b1;
            end else if (sub_store_c) begin
                bus.stall = 1'b1;
            end
        end
    end

    assign bus.load_data  = bad_c ? '0 : aligned_c;
    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;

    // FSM, captured RMW word and the first-fault record.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            rmw_addr     <= '0;
            rmw_word     <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_rmw_c) begin
                        state    <= ST_WRITE;
                        rmw_addr <= bus.addr;
                        rmw_word <= merged_c;
                    end
                end
                ST_WRITE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            if ((state == ST_IDLE) && bad_c && !fault_q) begin
                fault_q      <= 1'b1;
                fault_addr_q <= bus.addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios then random traffic
// against a word-array reference model of memory and fault state.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int unsigned DM_ADDR_W = 12;
    localparam int unsigned N_WORDS   = 1024;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.DM_ADDR_W(DM_ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Word-only data memory seen by the DUT.
    logic [31:0] mem [N_WORDS] = '{default: '0};
    assign bus.dm_rdata = mem[bus.dm_addr[11:2]];
    always @(posedge clock) begin
        if (bus.dm_we) mem[bus.dm_addr[11:2]] <= bus.dm_wdata;
    end

    // Reference model state.
    logic [31:0] ref_mem [N_WORDS];
    logic        m_fault;
    logic [31:0] m_fault_addr;

    function automatic logic m_bad(input mem_op_e op, input logic [31:0] a);
        int unsigned align;
        if (op == OP_LW || op == OP_SW) align = 4;
        else if (op == OP_LH || op == OP_LHU || op == OP_SH) align = 2;
        else align = 1;
        return (a >= (32'd1 << DM_ADDR_W)) || ((a % align) != 0);
    endfunction

    function automatic logic m_is_load(input mem_op_e op);
        return op == OP_LW || op == OP_LH || op == OP_LHU || op == OP_LB || op == OP_LBU;
    endfunction

    function automatic logic [31:0] m_load(input mem_op_e op, input logic [31:0] word, input logic [31:0] a);
        int unsigned sh = 8 * (a % 4);
        logic [31:0] b = (word >> sh) & 32'hFF;
        logic [31:0] h = (word >> sh) & 32'hFFFF;
        case (op)
            OP_LB:   return (b >= 32'd128)   ? b - 32'd256   : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'd32768) ? h - 32'd65536 : h;
            OP_LHU:  return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input mem_op_e op, input logic [31:0] word,
                                            input logic [31:0] a, input logic [31:0] wd);
        int unsigned sh = 8 * (a % 4);
        case (op)
            OP_SB:   return (word & ~(32'hFF << sh))   | ((wd & 32'hFF) << sh);
            OP_SH:   return (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            default: return wd;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction from issue to retirement; called #1 after a rising edge.
    task automatic do_op(input mem_op_e op, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] ld);
        logic        bad;
        logic        rmw;
        logic [31:0] word;
        logic [31:0] nw;
        bus.mem_req = 1'b1;
        bus.mem_op  = op;
        bus.addr    = a;
        bus.wdata   = wd;
        #1;
        bad  = m_bad(op, a);
        word = ref_mem[a[11:2]];
        rmw  = !bad && (op == OP_SB || op == OP_SH);
        ld   = bus.load_data;
        chk("dm_we_first", 32'(bus.dm_we), 32'(!bad && op == OP_SW));
        chk("stall_first", 32'(bus.stall), 32'(rmw));
        if (bad) chk("load_bad_zero", bus.load_data, 32'd0);
        else if (m_is_load(op)) chk("load_data", bus.load_data, m_load(op, word, a));
        if (!bad && op == OP_SW) begin
            chk("sw_wdata", bus.dm_wdata, wd);
            chk("sw_addr", bus.dm_addr, a);
            ref_mem[a[11:2]] = wd;
        end
        if (bad && !m_fault) begin
            m_fault      = 1'b1;
            m_fault_addr = a;
        end
        @(posedge clock);
        #1;
        if (rmw) begin
            nw = m_store(op, word, a, wd);
            chk("rmw_we", 32'(bus.dm_we), 32'd1);
            chk("rmw_stall", 32'(bus.stall), 32'd0);
            chk("rmw_wdata", bus.dm_wdata, nw);
            chk("rmw_addr", bus.dm_addr, a);
            ref_mem[a[11:2]] = nw;
            @(posedge clock);
            #1;
        end
        chk("fault", 32'(bus.fault), 32'(m_fault));
        chk("fault_addr", bus.fault_addr, m_fault_addr);
        bus.mem_req = 1'b0;
    endtask

    task automatic idle_cycle(input logic [31:0] a);
        bus.mem_req = 1'b0;
        bus.addr    = a;
        #1;
        chk("idle_we", 32'(bus.dm_we), 32'd0);
        chk("idle_stall", 32'(bus.stall), 32'd0);
        chk("idle_addr", bus.dm_addr, a);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ld;
        logic [31:0] a;
        mem_op_e     op;

        for (int i = 0; i < int'(N_WORDS); i++) ref_mem[i] = 32'd0;
        m_fault      = 1'b0;
        m_fault_addr = 32'd0;
        bus.mem_req  = 1'b0;
        bus.mem_op   = OP_LW;
        bus.addr     = 32'd0;
        bus.wdata    = 32'd0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_fault_addr", bus.fault_addr, 32'd0);
        chk("rst_we", 32'(bus.dm_we), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Byte/halfword load extraction and extension
        do_op(OP_SW, 32'h10, 32'h8899AABB, ld);
        do_op(OP_LB, 32'h11, 32'h0, ld);
        chk("t1_lb", ld, 32'hFFFFFFAA);
        do_op(OP_LBU, 32'h13, 32'h0, ld);
        chk("t1_lbu", ld, 32'h00000088);
        do_op(OP_LH, 32'h12, 32'h0, ld);
        chk("t1_lh", ld, 32'hFFFF8899);
        do_op(OP_LHU, 32'h10, 32'h0, ld);
        chk("t1_lhu", ld, 32'h0000AABB);

        // Word store and readback
        do_op(OP_SW, 32'h20, 32'h12345678, ld);
        do_op(OP_LW, 32'h20, 32'h0, ld);
        chk("t2_lw", ld, 32'h12345678);

        // Byte and halfword read-modify-write
        do_op(OP_SB, 32'h21, 32'h000000CC, ld);
        chk("t3_word", mem[8], 32'h1234CC78);
        do_op(OP_SH, 32'h32, 32'h0000BEEF, ld);
        chk("t4_word", mem[12], 32'hBEEF0000);

        // Misaligned then out-of-range: first fault address sticks, no write
        do_op(OP_LW, 32'h41, 32'h0, ld);
        chk("t5_fault_addr", bus.fault_addr, 32'h41);
        do_op(OP_SW, 32'h1000, 32'hDEADBEEF, ld);
        chk("t5_mem0", mem[0], 32'h0);
        chk("t5_fault_addr_kept", bus.fault_addr, 32'h41);

        // Reset arriving while the RMW write is pending
        do_op(OP_SW, 32'h50, 32'hA5A5A5A5, ld);
        bus.mem_req = 1'b1;
        bus.mem_op  = OP_SB;
        bus.addr    = 32'h52;
        bus.wdata   = 32'h00000011;
        #1;
        chk("t6_stall", 32'(bus.stall), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_no_write", 32'(bus.dm_we), 32'd0);
        @(posedge clock);
        #1;
        reset       = 1'b0;
        bus.mem_req = 1'b0;
        m_fault      = 1'b0;
        m_fault_addr = 32'd0;
        chk("t6_fault", 32'(bus.fault), 32'd0);
        chk("t6_word", mem[20], 32'hA5A5A5A5);
        do_op(OP_LW, 32'h50, 32'h0, ld);
        chk("t6_readback", ld, 32'hA5A5A5A5);

        // Random traffic over a small window so stores and loads collide
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle_cycle($urandom);
            end else begin
                op = mem_op_e'($urandom_range(0, 7));
                if ($urandom_range(0, 19) == 0) begin
                    a = 32'h1000 | $urandom;
                end else begin
                    a = 32'($urandom_range(0, 63)) * 32'd4;
                    if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(0, 3));
                    else if (op == OP_LB || op == OP_LBU || op == OP_SB) a = a + 32'($urandom_range(0, 3));
                    else if (op == OP_LH || op == OP_LHU || op == OP_SH) a = a + 32'd2 * 32'($urandom_range(0, 1));
                end
                do_op(op, a, $urandom, ld);
            end
        end

        for (int i = 0; i < int'(N_WORDS); i++) chk("mem_word", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
